pdm_cic_decimator: RTL

Third-order CIC decimation filter that consumes the 1-bit serial bitstream (one bit per clk, MSB-first shift source) and produces signed 8-bit PCM samples at clk/R, each with a one-cycle valid strobe. It is the first stage of the filter and decimator chain. It sits directly downstream of the serial data source and upstream of the fractional (16/11) resampler.

---
 rtl/cic_pkg.sv | 27 ++
 rtl/cic_integrator_stage.sv | 24 ++
 rtl/pdm_cic_decimator.sv | 62 ++++++
 3 files changed

// File: rtl/cic_pkg.sv
// Shared definitions for the third-order CIC PDM decimator.
//   R      : decimation ratio (power of two, >= 8)
//   CNT_W  : phase counter width, log2(R)
//   W_ACC  : signed accumulator width, wide enough that modular wrap is
//            cancelled exactly by the comb section
//   SHIFT  : arithmetic right shift that maps the R^3 gain onto 8 bits
//   acc_t  : signed accumulator type
//   sat8() : clamp an accumulator value to the signed 8-bit range
package cic_pkg;

   localparam int R     = 16;
   localparam int CNT_W = $clog2(R);
   localparam int W_ACC = 2 + 3 * CNT_W;
   localparam int SHIFT = 3 * CNT_W - 7;

   typedef logic signed [W_ACC-1:0] acc_t;

   function automatic logic signed [7:0] sat8(input acc_t v);
      if (v > acc_t'(127))
         return 8'sh7f;
      else if (v < acc_t'(-128))
         return 8'sh80;
      else
         return v[7:0];
   endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// One CIC integrator: registered accumulator, W_ACC wide. The add is
// deliberately modular; overflow wraps and is undone by the combs.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset, clears the accumulator
//   din     : value added every clock
//   acc     : accumulator state
module cic_integrator_stage
   import cic_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  acc_t din,
   output acc_t acc
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         acc <= '0;
      else
         acc <= acc + din;
   end

endmodule

// File: rtl/pdm_cic_decimator.sv
// Third-order CIC decimator (M=1) turning a 1-bit PDM stream into signed
// 8-bit PCM at clk/R. Three integrators run every clock; the comb section
// is evaluated combinationally from the integrator output and only its
// delay registers are updated on the decimation edge (cnt == R-1).
// Ports:
//   clk        : system clock, one input bit per rising edge
//   reset_n    : asynchronous active-low reset
//   data       : PDM bit, 1 -> +1, 0 -> -1
//   dout       : signed PCM sample, held between strobes
//   dout_valid : one-cycle strobe marking a new dout
module pdm_cic_decimator
   import cic_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              data,
   output logic signed [7:0] dout,
   output logic              dout_valid
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(R - 1);

   acc_t x;
   acc_t i1, i2, i3;
   acc_t d1, d2, d3;
   acc_t c1, c2, c3;
   logic [CNT_W-1:0] cnt;

   // '1 is -1 in two's complement at the accumulator width
   assign x = data ? acc_t'(1) : '1;

   cic_integrator_stage u_int1 (.clk(clk), .reset_n(reset_n), .din(x),  .acc(i1));
   cic_integrator_stage u_int2 (.clk(clk), .reset_n(reset_n), .din(i1), .acc(i2));
   cic_integrator_stage u_int3 (.clk(clk), .reset_n(reset_n), .din(i2), .acc(i3));

   assign c1 = i3 - d1;
   assign c2 = c1 - d2;
   assign c3 = c2 - d3;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt        <= '0;
         d1         <= '0;
         d2         <= '0;
         d3         <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         // R is a power of two, so the natural rollover gives the R-1 -> 0 wrap
         cnt        <= cnt + 1'b1;
         dout_valid <= 1'b0;
         if (cnt == CNT_LAST) begin
            d1         <= i3;
            d2         <= c1;
            d3         <= c2;
            dout       <= sat8(c3 >>> SHIFT);
            dout_valid <= 1'b1;
         end
      end
   end

endmodule
